// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage ahead of the control unit.
// Holds PC and IR, fetches words over a req/ack handshake and computes the
// next PC from control's M2/M13 selects when control strobes pc_flag.
// Optional build macro: FETCH_STALL_CNT_EN adds a saturating count of
// cycles spent waiting in REQ for imem_ack.
module fetch_unit #(
  parameter int              ADDR_W   = 16,
  parameter int              DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_flag,
  input  logic              M2,
  input  logic              M13,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_ack,
  output logic [ADDR_W-1:0] pc,
  output logic              instr_valid,
  output logic              fetch_busy,
  output logic [3:0]        opcode,
  output logic [3:0]        rd,
  output logic [3:0]        rs,
  output logic [3:0]        rt,
  output logic [15:0]       imm,
  output logic [15:0]       stall_cnt
);

  // Wide enough to sign-extend the 16-bit immediate and to cover the PC.
  localparam int EXT_W = (ADDR_W > 16) ? ADDR_W : 16;

  typedef enum logic [1:0] {IDLE, REQ, READY} state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   ir;
  logic [ADDR_W-1:0]   next_pc;
  logic [ADDR_W-1:0]   seq_pc;
  logic signed [EXT_W-1:0] imm_ext;
  logic                load_ir;
  logic                adv_pc;

  // State register; reset returns to IDLE so one idle cycle precedes a fetch.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake decode; pc_flag only matters in READY, ack only in REQ.
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    load_ir   = 1'b0;
    adv_pc    = 1'b0;
    case (state)
      IDLE:  state_nxt = REQ;
      REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          load_ir   = 1'b1;
          state_nxt = READY;
        end
      end
      READY: begin
        if (pc_flag) begin
          adv_pc    = 1'b1;
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next PC: sequential, absolute jump from IR, or PC-relative branch; all mod 2^ADDR_W.
  always_comb begin
    imm_ext = EXT_W'($signed(ir[15:0]));
    seq_pc  = pc + ADDR_W'(1);
    next_pc = seq_pc;
    if (M2) begin
      if (M13) next_pc = ir[ADDR_W-1:0];
      else     next_pc = seq_pc + imm_ext[ADDR_W-1:0];
    end
  end

  // PC and IR; reset wins over a simultaneous ack or accepted pc_flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc <= RESET_PC;
      ir <= '0;
    end else begin
      if (load_ir) ir <= imem_rdata;
      if (adv_pc)  pc <= next_pc;
    end
  end

  assign instr_valid = (state == READY);
  assign fetch_busy  = ~instr_valid;
  assign imem_addr   = pc;

  assign opcode = ir[31:28];
  assign rd     = ir[27:24];
  assign rs     = ir[23:20];
  assign rt     = ir[19:16];
  assign imm    = ir[15:0];

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_q;

  // Count REQ cycles without ack; saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (!reset)                                        stall_q <= '0;
    else if (state == REQ && !imem_ack && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven fetch/advance vectors with a scoreboard of
// expected fetched instructions, plus hand sequences for stall and reset-in-REQ.
module tb_fetch_unit;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam logic [15:0] RST_PC = 16'h0010;

  logic              clk;
  logic              reset;
  logic              pc_flag, M2, M13;
  logic              imem_req, imem_ack;
  logic [ADDR_W-1:0] imem_addr, pc;
  logic [DATA_W-1:0] imem_rdata;
  logic              instr_valid, fetch_busy;
  logic [3:0]        opcode, rd, rs, rt;
  logic [15:0]       imm, stall_cnt;

  fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .pc_flag(pc_flag), .M2(M2), .M13(M13),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ack(imem_ack), .pc(pc), .instr_valid(instr_valid),
    .fetch_busy(fetch_busy), .opcode(opcode), .rd(rd), .rs(rs), .rt(rt),
    .imm(imm), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          waits;
    logic        m2;
    logic        m13;
    logic [15:0] next_pc;
  } vec_t;

  typedef struct {
    logic [15:0] pc;
    logic [31:0] data;
  } exp_t;

  vec_t vecs[9];
  exp_t sb[$];
  exp_t e;
  int   n_chk = 0, n_fail = 0, n_push = 0, n_pop = 0;
  int   stall_exp = 0;
  logic [15:0] exp_pc;
  logic prev_v = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_req();
    for (int i = 0; i < 10 && imem_req !== 1'b1; i++) @(negedge clk);
    chk("req_seen", 32'(imem_req), 32'd1);
  endtask

  task automatic chk_stall(input string name);
`ifdef FETCH_STALL_CNT_EN
    chk(name, 32'(stall_cnt), 32'(stall_exp));
`else
    chk(name, 32'(stall_cnt), 32'd0);
`endif
  endtask

  // Scoreboard monitor: each rising instr_valid must match the oldest expected fetch.
  always @(negedge clk) begin
    if (instr_valid === 1'b1 && prev_v !== 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        n_pop++;
        chk("mon_pc",     32'(pc),     32'(e.pc));
        chk("mon_opcode", 32'(opcode), 32'(e.data[31:28]));
        chk("mon_rd",     32'(rd),     32'(e.data[27:24]));
        chk("mon_rs",     32'(rs),     32'(e.data[23:20]));
        chk("mon_rt",     32'(rt),     32'(e.data[19:16]));
        chk("mon_imm",    32'(imm),    32'(e.data[15:0]));
        chk("mon_busy",   32'(fetch_busy), 32'd0);
      end
    end
    prev_v = instr_valid;
  end

  initial begin
    vecs[0] = '{32'h4123_0005, 0, 1'b0, 1'b0, 16'h0011};
    vecs[1] = '{32'h7000_0020, 1, 1'b1, 1'b1, 16'h0020};
    vecs[2] = '{32'h1000_FFFC, 0, 1'b1, 1'b0, 16'h001D};
    vecs[3] = '{32'h7000_1234, 2, 1'b1, 1'b1, 16'h1234};
    vecs[4] = '{32'h7000_FFFF, 0, 1'b1, 1'b1, 16'hFFFF};
    vecs[5] = '{32'h0000_0000, 3, 1'b0, 1'b0, 16'h0000};
    vecs[6] = '{32'h2000_7FFF, 0, 1'b1, 1'b0, 16'h8000};
    vecs[7] = '{32'h3000_8000, 1, 1'b1, 1'b0, 16'h0001};
    vecs[8] = '{32'h5FFF_0010, 0, 1'b0, 1'b1, 16'h0002};

    reset = 1'b0; pc_flag = 1'b0; M2 = 1'b0; M13 = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0;
    repeat (2) @(negedge clk);

    chk("rst_req",   32'(imem_req),    32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_busy",  32'(fetch_busy),  32'd1);
    chk("rst_pc",    32'(pc),          32'(RST_PC));
    chk("rst_opcode",32'(opcode),      32'd0);
    chk("rst_imm",   32'(imm),         32'd0);
    chk("rst_stall", 32'(stall_cnt),   32'd0);

    // Release reset; exactly one idle cycle, then a request.
    reset = 1'b1;
    exp_pc = RST_PC;
    @(negedge clk);
    chk("idle_one_cycle", 32'(imem_req), 32'd1);

    for (int v = 0; v < 9; v++) begin
      wait_req();
      chk("req_addr", 32'(imem_addr), 32'(exp_pc));
      for (int w = 0; w < vecs[v].waits; w++) begin
        imem_ack = 1'b0; pc_flag = ~pc_flag; M2 = 1'b1; M13 = 1'b1;
        @(negedge clk);
        stall_exp++;
        chk("wait_req_held", 32'(imem_req), 32'd1);
        chk("wait_pc_held",  32'(pc),       32'(exp_pc));
      end
      pc_flag = 1'b0;
      imem_ack = 1'b1; imem_rdata = vecs[v].data;
      sb.push_back('{exp_pc, vecs[v].data});
      n_push++;
      @(negedge clk);
      chk_stall("stall_cnt");
      // Ack while READY must not disturb IR.
      imem_ack = 1'b1; imem_rdata = ~vecs[v].data;
      @(negedge clk);
      imem_ack = 1'b0;
      chk("ready_valid",  32'(instr_valid), 32'd1);
      chk("ready_opcode", 32'(opcode),      32'(vecs[v].data[31:28]));
      chk("ready_imm",    32'(imm),         32'(vecs[v].data[15:0]));
      pc_flag = 1'b1; M2 = vecs[v].m2; M13 = vecs[v].m13;
      @(negedge clk);
      pc_flag = 1'b0; M2 = 1'($urandom); M13 = 1'($urandom);
      chk("next_pc",     32'(pc),          32'(vecs[v].next_pc));
      chk("adv_invalid", 32'(instr_valid), 32'd0);
      chk("adv_busy",    32'(fetch_busy),  32'd1);
      exp_pc = vecs[v].next_pc;
    end

    // Fresh reset, pc_flag asserted during IDLE must be ignored.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1; pc_flag = 1'b1; stall_exp = 0;
    @(negedge clk);
    pc_flag = 1'b0;
    chk("r2_req",  32'(imem_req),  32'd1);
    chk("r2_addr", 32'(imem_addr), 32'(RST_PC));

    // Withheld ack for 3 cycles with pc_flag toggling.
    for (int w = 0; w < 3; w++) begin
      imem_ack = 1'b0; pc_flag = ~pc_flag;
      @(negedge clk);
      stall_exp++;
      chk("stall_pc_held", 32'(pc), 32'(RST_PC));
    end
    chk_stall("stall_three");

    // Reset mid-REQ with a simultaneous ack: ack discarded, req drops.
    reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; pc_flag = 1'b1;
    @(negedge clk);
    stall_exp = 0;
    chk("rreq_req",    32'(imem_req),    32'd0);
    chk("rreq_pc",     32'(pc),          32'(RST_PC));
    chk("rreq_valid",  32'(instr_valid), 32'd0);
    chk("rreq_opcode", 32'(opcode),      32'd0);
    chk_stall("rreq_stall");
    reset = 1'b1; imem_ack = 1'b0; pc_flag = 1'b0;
    @(negedge clk);
    chk("restart_req",  32'(imem_req),  32'd1);
    chk("restart_addr", 32'(imem_addr), 32'(RST_PC));

    // Complete the restarted fetch.
    imem_ack = 1'b1; imem_rdata = 32'h4123_0005;
    sb.push_back('{RST_PC, 32'h4123_0005});
    n_push++;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);

    chk("sb_drained",  32'(sb.size()), 32'd0);
    chk("pop_count",   32'(n_pop),     32'(n_push));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
